// File: rtl/cacheline_req_sched.sv
// Request scheduler in front of the PLRU cacheline: FIFO of tagged lookups, per-domain
// way-partition table, domain-switch insertion. Optional stats via CACHELINE_SCHED_STATS_EN.
module cacheline_req_sched #(
  parameter int NUM_WAYS    = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DOMAINS = 4,
  parameter int FIFO_DEPTH  = 4,
  localparam int DOM_W      = $clog2(NUM_DOMAINS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DOM_W-1:0]      req_dom,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  cfg_we,
  input  logic [DOM_W-1:0]      cfg_dom,
  input  logic [NUM_WAYS-1:0]   cfg_hitmap,
  output logic                  os_req,
  output logic [NUM_WAYS-1:0]   hitmap,
  output logic                  user_req,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  hit,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  busy
`ifdef CACHELINE_SCHED_STATS_EN
  ,
  output logic [15:0]           stat_hits,
  output logic [15:0]           stat_misses,
  output logic [15:0]           stat_switches
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SWITCH, LOOKUP} state_t;

  logic [DOM_W-1:0]      fifo_dom  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  full, empty, push, pop;
  logic [DOM_W-1:0]      head_dom;
  logic [ADDR_WIDTH-1:0] head_addr;

  logic [NUM_WAYS-1:0]   dom_tbl [NUM_DOMAINS];
  logic [DOM_W-1:0]      cur_dom;
  logic                  cur_valid;
  logic                  head_match;

  state_t state, next_state;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head_dom  = fifo_dom[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];
  assign head_match = cur_valid && (head_dom == cur_dom);

  // FIFO storage carries no reset; occupancy and pointers do
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dom[wr_ptr]  <= req_dom;
      fifo_addr[wr_ptr] <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State names the command being driven this cycle; the head is popped on entry to LOOKUP
  always_comb begin
    next_state = IDLE;
    case (state)
      SWITCH:  next_state = LOOKUP;
      default: begin
        if (empty)            next_state = IDLE;
        else if (!head_match) next_state = SWITCH;
        else                  next_state = LOOKUP;
      end
    endcase
  end

  assign pop = (next_state == LOOKUP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOMAINS; i++) dom_tbl[i] <= '0;
      cur_dom   <= '0;
      cur_valid <= 1'b0;
    end else begin
      if (cfg_we) dom_tbl[cfg_dom] <= cfg_hitmap;
      if (next_state == SWITCH) begin
        cur_dom   <= head_dom;
        cur_valid <= !(cfg_we && (cfg_dom == head_dom));
      end else if (cfg_we && (cfg_dom == cur_dom)) begin
        cur_valid <= 1'b0;
      end
    end
  end

  // Command stage: registered outputs to the cacheline
  always_ff @(posedge clk) begin
    if (reset) begin
      os_req   <= 1'b0;
      hitmap   <= '0;
      user_req <= 1'b0;
      addr     <= '0;
    end else begin
      os_req   <= (next_state == SWITCH);
      hitmap   <= (next_state == SWITCH) ? dom_tbl[head_dom] : '0;
      user_req <= (next_state == LOOKUP);
      addr     <= (next_state == LOOKUP) ? head_addr : '0;
    end
  end

  // Response stage: one cycle behind the lookup command
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_addr  <= '0;
    end else begin
      resp_valid <= user_req;
      resp_addr  <= addr;
    end
  end

  assign resp_hit = resp_valid && hit;
  assign busy     = !empty || os_req || user_req || resp_valid;

`ifdef CACHELINE_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_switches <= '0;
    end else begin
      if (resp_valid && resp_hit)  stat_hits     <= sat_inc(stat_hits);
      if (resp_valid && !resp_hit) stat_misses   <= sat_inc(stat_misses);
      if (os_req)                  stat_switches <= sat_inc(stat_switches);
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_req_sched.sv
// Bench for cacheline_req_sched: directed steps plus random traffic, checked each cycle
// against a queue-based reference model of the scheduling rules.
module tb_cacheline_req_sched;
  localparam int NW = 8, AW = 8, ND = 4, FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [1:0]    req_dom;
  logic [AW-1:0] req_addr;
  logic          cfg_we;
  logic [1:0]    cfg_dom;
  logic [NW-1:0] cfg_hitmap;
  logic          os_req, user_req;
  logic [NW-1:0] hitmap;
  logic [AW-1:0] addr;
  logic          hit;
  logic          resp_valid, resp_hit;
  logic [AW-1:0] resp_addr;
  logic          busy;

  cacheline_req_sched #(.NUM_WAYS(NW), .ADDR_WIDTH(AW), .NUM_DOMAINS(ND), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dom(req_dom), .req_addr(req_addr),
    .cfg_we(cfg_we), .cfg_dom(cfg_dom), .cfg_hitmap(cfg_hitmap),
    .os_req(os_req), .hitmap(hitmap), .user_req(user_req), .addr(addr),
    .hit(hit), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_addr(resp_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]    dom;
    logic [AW-1:0] a;
  } ent_t;

  ent_t          q[$];
  logic [NW-1:0] tbl [ND];
  logic [1:0]    cur_dom;
  bit            cur_valid;
  bit            head_switched;
  logic          e_os, e_ur, e_rv;
  logic [NW-1:0] e_hm;
  logic [AW-1:0] e_addr, e_raddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < ND; i++) tbl[i] = '0;
    cur_dom = '0; cur_valid = 0; head_switched = 0;
    e_os = 0; e_ur = 0; e_rv = 0; e_hm = '0; e_addr = '0; e_raddr = '0;
  endtask

  // One clock edge of the scheduling rules, evaluated on the pre-edge state
  task automatic model_edge(input bit rv, input logic [1:0] d, input logic [AW-1:0] a,
                            input bit we, input logic [1:0] cd, input logic [NW-1:0] chm);
    bit ready = (q.size() < FD);
    int act;
    e_rv = e_ur; e_raddr = e_addr;
    e_os = 0; e_hm = '0; e_ur = 0; e_addr = '0;
    if (head_switched)                               act = 2;
    else if (q.size() == 0)                          act = 0;
    else if (!cur_valid || q[0].dom != cur_dom)      act = 1;
    else                                             act = 2;
    if (act == 1) begin
      e_os = 1; e_hm = tbl[q[0].dom];
      cur_dom = q[0].dom;
      cur_valid = !(we && cd == q[0].dom);
      head_switched = 1;
    end else begin
      if (we && cd == cur_dom) cur_valid = 0;
      if (act == 2) begin
        e_ur = 1; e_addr = q[0].a;
        void'(q.pop_front());
        head_switched = 0;
      end
    end
    if (we) tbl[cd] = chm;
    if (rv && ready) q.push_back({d, a});
  endtask

  task automatic check_outputs();
    check("os_req", os_req, e_os);
    check("hitmap", hitmap, e_hm);
    check("user_req", user_req, e_ur);
    check("addr", addr, e_addr);
    check("resp_valid", resp_valid, e_rv);
    check("resp_addr", resp_addr, e_raddr);
    check("busy", busy, (q.size() != 0) || e_os || e_ur || e_rv);
    check("os_and_user", os_req && user_req, 1'b0);
  endtask

  task automatic step(input bit rv, input logic [1:0] d, input logic [AW-1:0] a,
                      input bit we, input logic [1:0] cd, input logic [NW-1:0] chm);
    logic hv;
    hv = 1'($urandom_range(0, 1));
    req_valid = rv; req_dom = d; req_addr = a;
    cfg_we = we; cfg_dom = cd; cfg_hitmap = chm; hit = hv;
    #1;
    check("req_ready", req_ready, q.size() < FD);
    check("resp_hit", resp_hit, e_rv & hv);
    @(posedge clk);
    model_edge(rv, d, a, we, cd, chm);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, '0, 0, 2'd0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 0; req_dom = '0; req_addr = '0;
    cfg_we = 0; cfg_dom = '0; cfg_hitmap = '0; hit = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    check_outputs();
    check("reset_ready", req_ready, 1'b1);
    check("reset_resp_hit", resp_hit, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    idle(2);

    // configure dom1, then a single lookup that needs a switch
    step(0, 2'd0, '0, 1, 2'd1, 8'h0F);
    step(1, 2'd1, 8'h2A, 0, 2'd0, '0);
    idle(4);

    // four same-domain lookups back to back
    for (int i = 0; i < 4; i++) step(1, 2'd1, AW'(8'h40 + i), 0, 2'd0, '0);
    idle(5);

    // alternating domains held valid long enough to fill the FIFO
    step(0, 2'd0, '0, 1, 2'd0, 8'hF0);
    for (int i = 0; i < 8; i++) step(1, 2'(i % 2), AW'(8'h60 + i), 0, 2'd0, '0);
    idle(14);

    // rewrite the loaded domain's entry, then look it up again
    step(0, 2'd0, '0, 1, 2'd1, 8'h3C);
    step(1, 2'd1, 8'h77, 0, 2'd0, '0);
    idle(4);

    // table write to the head domain in the same cycle as its switch
    step(1, 2'd2, 8'h81, 0, 2'd0, '0);
    step(0, 2'd0, '0, 1, 2'd2, 8'hAA);
    step(1, 2'd2, 8'h82, 0, 2'd0, '0);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), AW'($urandom),
           ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), NW'($urandom));
    idle(12);

    // reset in the middle of a burst with entries queued
    for (int i = 0; i < 5; i++) step(1, 2'(i % 2), AW'(8'h90 + i), 0, 2'd0, '0);
    check("queued_before_reset", busy, 1'b1);
    do_reset();
    idle(4);
    step(0, 2'd0, '0, 1, 2'd1, 8'h0F);
    step(1, 2'd1, 8'hB5, 0, 2'd0, '0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_req_sched.md
# cacheline_req_sched

Request scheduler that sits directly upstream of the PLRU cacheline and drives its `os_req`/`hitmap`/`user_req`/`addr` inputs. It buffers tagged user lookups in a small FIFO and keeps a per-domain way-partition table. It inserts a domain-switch command whenever the head request's domain differs from the one currently loaded in the cacheline. It returns one hit/miss response per issued lookup.

## Interface
Parameters:
- `NUM_WAYS`, 8, ways in the cacheline; width of `hitmap`.
- `ADDR_WIDTH`, 8, lookup address/tag width.
- `NUM_DOMAINS`, 4, number of domain table entries; power of 2, at least 2.
- `FIFO_DEPTH`, 4, request FIFO entries; power of 2, at least 2.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: user lookup offered.
- `req_ready` out 1: FIFO can accept; equals `!full`.
- `req_dom` in log2(NUM_DOMAINS): domain of the lookup.
- `req_addr` in ADDR_WIDTH: lookup address.
- `cfg_we` in 1: write domain table entry.
- `cfg_dom` in log2(NUM_DOMAINS): entry to write.
- `cfg_hitmap` in NUM_WAYS: way partition for that entry.
- `os_req` out 1: registered; domain-switch command to the cacheline.
- `hitmap` out NUM_WAYS: registered; partition sent with `os_req`; 0 otherwise.
- `user_req` out 1: registered; lookup command to the cacheline.
- `addr` out ADDR_WIDTH: registered; lookup address; 0 when idle.
- `hit` in 1: cacheline hit flag, valid in the cycle after `user_req`.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_hit` out 1: equals `hit` while `resp_valid`=1; 0 otherwise.
- `resp_addr` out ADDR_WIDTH: address of the responding lookup.
- `busy` out 1: FIFO non-empty, or a command or response is outstanding.

## Operation
- **FIFO:** holds {dom, addr}.
  - Push when `req_valid && req_ready`.
  - No bypass; a request reaches the head one cycle after its push at the earliest.
  - When full, `req_ready`=0 even if a pop occurs in the same cycle.
- **Domain table:** NUM_DOMAINS × NUM_WAYS.
  - Reset value is all 0.
  - `cfg_we` writes the entry at the clock edge.
  - A write to `cur_dom` while `cur_valid`=1 clears `cur_valid`.
- **Tracking:** `cur_dom` and `cur_valid` record the partition last loaded into the cacheline. Reset: `cur_dom`=0, `cur_valid`=0.
- **FSM states:** IDLE, SWITCH, LOOKUP.
  - **IDLE:** if the FIFO is empty, stay in IDLE. Otherwise:
    - if head dom ≠ `cur_dom` or `cur_valid`=0, go to SWITCH;
    - else go to LOOKUP.
  - **SWITCH:** register `os_req`=1 and `hitmap`=table[head dom]. Set `cur_dom`=head dom and `cur_valid`=1. Next state is LOOKUP. The head is not popped.
  - **LOOKUP:** register `user_req`=1 and `addr`=head addr, and pop the head. Next state is chosen from the new head by the same rule as IDLE, or IDLE if the FIFO is empty. Same-domain requests therefore issue back-to-back, one per cycle.
- `os_req` and `user_req` are never 1 in the same cycle. Each is a single-cycle pulse per command.
- **Table snapshot:** if a `cfg_we` to the head domain coincides with SWITCH, the old table value is sent. `cur_valid` is still cleared, so the next request re-switches.
- **Response:** `resp_valid` is `user_req` delayed by 1 cycle; `resp_addr` is `addr` delayed by 1 cycle. `resp_hit` passes `hit` through combinationally, gated by `resp_valid`. There is no response backpressure.
- **Reset (including mid-operation):**
  - FIFO emptied, state IDLE, table cleared.
  - All outputs 0, except `req_ready`=1 from the first cycle after reset.
  - An outstanding response is discarded.

## Timing
- Lookup, same domain as loaded, empty pipeline:
  - push at edge E0;
  - head visible at E0, `user_req` registered at E1 (high E1–E2);
  - cacheline processes at E2;
  - `resp_valid` high E2–E3.
  - Push-to-response latency is 2 cycles.
- A domain switch adds 1 cycle.
- Throughput: 1 lookup/cycle when domains match; a switch costs one bubble.

## Configuration
- `CACHELINE_SCHED_STATS_EN` defined adds outputs `stat_hits`, `stat_misses` and `stat_switches`, each 16 bits.
  - Each counter increments on `resp_valid&&resp_hit`, `resp_valid&&!resp_hit` and `os_req` respectively.
  - Counters saturate at 0xFFFF and clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then `cfg` dom1=8'h0F, push {dom1, 0x2A}:
  - `os_req`=1 with `hitmap`=0x0F;
  - next cycle `user_req`=1 with `addr`=0x2A;
  - next cycle `resp_valid`=1, `resp_addr`=0x2A, `resp_hit`=`hit`.
- Push 4 lookups all in dom1 after dom1 is loaded: exactly 4 consecutive `user_req` cycles, no `os_req`, and `resp_valid` high 4 consecutive cycles.
- Alternate dom0/dom1 lookups (table 0xF0/0x0F): each lookup is preceded by exactly one `os_req` with the correct hitmap, and `os_req`&&`user_req` is never 1.
- Hold `req_valid`=1 for 6 cycles with the FIFO stalled behind a switch: `req_ready` drops when 4 entries are held and no request is lost or duplicated.
- Write the table entry of the current domain, then push a lookup in that domain: a fresh `os_req` carries the new hitmap.
- Assert `reset` mid-burst with 3 entries queued: no further `user_req` or `resp_valid`, `busy`=0, and a following lookup re-switches.
